// File: rtl/vga_pkg.sv
// Shared VGA pipeline definitions: screen geometry, menu colours and the
// menu selection control types used by menu_select.
package vga_pkg;

    // Visible area of the 800x600 timing used by the pipeline.
    localparam int HOR_PIXELS = 800;
    localparam int VER_PIXELS = 600;

    // Menu palette; MENU_BG_COLOR is also produced by the background stage.
    localparam logic [11:0] MENU_BG_COLOR   = 12'h124;
    localparam logic [11:0] MENU_ITEM_COLOR = 12'h468;
    localparam logic [11:0] MENU_HL_COLOR   = 12'hFA0;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } menu_sel_state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } menu_dir_t;

    // One cursor step with wrap-around at both ends of the list.
    function automatic logic [2:0] menu_step(input logic [2:0] idx,
                                             input menu_dir_t   dir,
                                             input logic [2:0]  last);
        logic [2:0] nxt;
        if (dir == DIR_UP) begin
            nxt = (idx == 3'd0) ? last : idx - 3'd1;
        end else begin
            nxt = (idx == last) ? 3'd0 : idx + 3'd1;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/menu_select_btn_edge.sv
// Rising-edge detector for one debounced button level. The history flop
// resets to 1 so a button already held when reset releases never fires.
module btn_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic rise_o
);

    logic prev_q;

    // Remember last cycle's button level.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= btn_i;
        end
    end

    assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/menu_select.sv
// Menu selection stage: overlays N_ITEMS boxes on the menu background,
// highlights the selected one, moves the cursor from button edges only at
// frame start, and strobes sel_valid_o when enter is pressed.
// Optional feature: define MENU_SEL_BLINK_EN to blink the highlight
// (16 frames on, 16 frames off).
module menu_select
    import vga_pkg::*;
#(
    parameter int N_ITEMS  = 4,
    parameter int ITEM_X   = 256,
    parameter int ITEM_W   = 512,
    parameter int ITEM_Y0  = 200,
    parameter int ITEM_H   = 64,
    parameter int ITEM_GAP = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_up_i,
    input  logic        btn_down_i,
    input  logic        btn_enter_i,
    input  logic [10:0] in_hcount_i,
    input  logic [10:0] in_vcount_i,
    input  logic        in_hsync_i,
    input  logic        in_vsync_i,
    input  logic        in_hblnk_i,
    input  logic        in_vblnk_i,
    input  logic [11:0] in_rgb_i,
    output logic [10:0] out_hcount_o,
    output logic [10:0] out_vcount_o,
    output logic        out_hsync_o,
    output logic        out_vsync_o,
    output logic        out_hblnk_o,
    output logic        out_vblnk_o,
    output logic [11:0] out_rgb_o,
    output logic [2:0]  sel_idx_o,
    output logic        sel_valid_o
);

    // Box geometry folded into 11-bit constants; all hit arithmetic is 11-bit.
    localparam logic [10:0] X_LO      = 11'(ITEM_X);
    localparam logic [10:0] X_HI      = 11'(ITEM_X + ITEM_W);
    localparam logic [10:0] Y_FIRST   = 11'(ITEM_Y0);
    localparam logic [10:0] BOX_H     = 11'(ITEM_H);
    localparam logic [10:0] PITCH     = 11'(ITEM_H + ITEM_GAP);
    localparam logic [10:0] FS_VCOUNT = 11'(VER_PIXELS);
    localparam logic [2:0]  LAST_IDX  = 3'(N_ITEMS - 1);

    // ------------------------------------------------------------------
    // Button edges
    // ------------------------------------------------------------------
    logic up_rise;
    logic down_rise;
    logic enter_rise;

    btn_edge u_edge_up (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_up_i),
        .rise_o (up_rise)
    );

    btn_edge u_edge_down (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_down_i),
        .rise_o (down_rise)
    );

    btn_edge u_edge_enter (
        .clk    (clk),
        .rst    (rst),
        .btn_i  (btn_enter_i),
        .rise_o (enter_rise)
    );

    // First pixel of the vertical blanking interval marks a new frame.
    logic fs;
    assign fs = (in_vcount_i == FS_VCOUNT) && (in_hcount_i == 11'd0);

    // ------------------------------------------------------------------
    // Selection control
    // ------------------------------------------------------------------
    menu_sel_state_t state_q, state_d;
    menu_dir_t       dir_q, dir_d;
    logic [2:0]      sel_idx_q, sel_idx_d;
    logic            sel_valid_q, sel_valid_d;

    // Control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            dir_q       <= DIR_UP;
            sel_idx_q   <= 3'd0;
            sel_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            sel_idx_q   <= sel_idx_d;
            sel_valid_q <= sel_valid_d;
        end
    end

    // Next-state logic: enter always takes priority over a direction press,
    // and a direction is only committed at frame start so no frame tears.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        sel_idx_d   = sel_idx_q;
        sel_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (enter_rise) begin
                    sel_valid_d = 1'b1;
                end else if (up_rise ^ down_rise) begin
                    dir_d   = up_rise ? DIR_UP : DIR_DOWN;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (enter_rise) begin
                    sel_valid_d = 1'b1;
                end
                if (fs) begin
                    sel_idx_d = menu_step(sel_idx_q, dir_q, LAST_IDX);
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sel_idx_o   = sel_idx_q;
    assign sel_valid_o = sel_valid_q;

    // ------------------------------------------------------------------
    // Highlight enable
    // ------------------------------------------------------------------
    logic hl_on;

`ifdef MENU_SEL_BLINK_EN
    logic [4:0] blink_cnt_q;

    // Free-running frame counter; its MSB splits 32 frames into on/off halves.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt_q <= 5'd0;
        end else if (fs) begin
            blink_cnt_q <= blink_cnt_q + 5'd1;
        end
    end

    assign hl_on = ~blink_cnt_q[4];
`else
    assign hl_on = 1'b1;
`endif

    // ------------------------------------------------------------------
    // Box hit test
    // ------------------------------------------------------------------
    logic        in_x;
    logic        hit;
    logic [2:0]  hit_idx;
    logic [10:0] y_top;
    logic [10:0] y_bot;

    assign in_x = (in_hcount_i >= X_LO) && (in_hcount_i < X_HI);

    // Find which (if any) box the current pixel falls in; boxes never overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 3'd0;
        y_top   = 11'd0;
        y_bot   = 11'd0;
        for (int i = 0; i < N_ITEMS; i++) begin
            y_top = Y_FIRST + 11'(i) * PITCH;
            y_bot = y_top + BOX_H;
            if (in_x && (in_vcount_i >= y_top) && (in_vcount_i < y_bot)) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Pixel colour
    // ------------------------------------------------------------------
    logic        blank;
    logic [11:0] rgb_d;

    assign blank = in_hblnk_i | in_vblnk_i;

    // Only paint over plain background; blanking and border tiles pass through.
    always_comb begin
        rgb_d = in_rgb_i;
        if (blank) begin
            rgb_d = in_rgb_i;
        end else if (in_rgb_i != MENU_BG_COLOR) begin
            rgb_d = in_rgb_i;
        end else if (hit && (hit_idx == sel_idx_q) && hl_on) begin
            rgb_d = MENU_HL_COLOR;
        end else if (hit) begin
            rgb_d = MENU_ITEM_COLOR;
        end
    end

    logic [10:0] hcount_q;
    logic [10:0] vcount_q;
    logic        hsync_q;
    logic        vsync_q;
    logic        hblnk_q;
    logic        vblnk_q;
    logic [11:0] rgb_q;

    // One-cycle output register for timing and overlaid colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_q <= 11'd0;
            vcount_q <= 11'd0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            hblnk_q  <= 1'b0;
            vblnk_q  <= 1'b0;
            rgb_q    <= 12'd0;
        end else begin
            hcount_q <= in_hcount_i;
            vcount_q <= in_vcount_i;
            hsync_q  <= in_hsync_i;
            vsync_q  <= in_vsync_i;
            hblnk_q  <= in_hblnk_i;
            vblnk_q  <= in_vblnk_i;
            rgb_q    <= rgb_d;
        end
    end

    assign out_hcount_o = hcount_q;
    assign out_vcount_o = vcount_q;
    assign out_hsync_o  = hsync_q;
    assign out_vsync_o  = vsync_q;
    assign out_hblnk_o  = hblnk_q;
    assign out_vblnk_o  = vblnk_q;
    assign out_rgb_o    = rgb_q;

endmodule
